// File: rtl/axis_dwidth_converter.sv
// axis_dwidth_converter: packs N narrow AXI-Stream beats into one wide word.
// Each accepted slave beat is written into the next lane of the output word
// register; the word is presented on the master side the cycle after its last
// lane (or a tlast beat) is accepted. Unfilled lanes read as zero.
// Optional macro AXIS_DWIDTH_STATS_EN adds word/packet transfer counters.
`timescale 1ns/1ps

module axis_dwidth_converter #(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_M_AXIS_DATA_WIDTH = 256,
  parameter int C_AXIS_TUSER_WIDTH  = 128
) (
  input  logic                               aclk,
  input  logic                               reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                               s_axis_tlast,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                               m_axis_tlast,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready
`ifdef AXIS_DWIDTH_STATS_EN
  ,
  output logic [31:0]                        stat_word_count,
  output logic [31:0]                        stat_pkt_count
`endif
);

  localparam int N      = C_M_AXIS_DATA_WIDTH / C_S_AXIS_DATA_WIDTH;
  localparam int SW     = C_S_AXIS_DATA_WIDTH;
  localparam int SK     = C_S_AXIS_DATA_WIDTH / 8;
  localparam int MW     = C_M_AXIS_DATA_WIDTH;
  localparam int MK     = C_M_AXIS_DATA_WIDTH / 8;
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N - 1);

  logic [MW-1:0]                 r_tdata;
  logic [MK-1:0]                 r_tkeep;
  logic [C_AXIS_TUSER_WIDTH-1:0] r_tuser;
  logic                          r_tlast;
  logic                          r_tvalid;
  logic [LANE_W-1:0]             r_lane;

  logic          w_accept;
  logic          w_xfer;
  logic          w_close;
  logic [MW-1:0] w_tdata_nxt;
  logic [MK-1:0] w_tkeep_nxt;

  assign s_axis_tready = !reset && (!r_tvalid || m_axis_tready);
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_xfer        = r_tvalid && m_axis_tready;
  assign w_close       = s_axis_tlast || (r_lane == LAST_LANE);

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;

  // Merge the incoming beat into its lane; a word still on the master side is
  // being transferred this cycle, so the new beat starts from a cleared word.
  always_comb begin
    w_tdata_nxt = r_tvalid ? '0 : r_tdata;
    w_tkeep_nxt = r_tvalid ? '0 : r_tkeep;
    for (int k = 0; k < N; k++) begin
      if (r_lane == LANE_W'(k)) begin
        w_tdata_nxt[k*SW +: SW] = s_axis_tdata;
        w_tkeep_nxt[k*SK +: SK] = s_axis_tkeep;
      end
    end
  end

  // Word accumulation, lane tracking and master-side handshake.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tuser  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
      r_lane   <= '0;
    end else if (w_accept) begin
      r_tdata <= w_tdata_nxt;
      r_tkeep <= w_tkeep_nxt;
      if (r_lane == '0) begin
        r_tuser <= s_axis_tuser;
      end
      if (w_close) begin
        r_tvalid <= 1'b1;
        r_tlast  <= s_axis_tlast;
        r_lane   <= '0;
      end else begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
        r_lane   <= r_lane + LANE_W'(1);
      end
    end else if (w_xfer) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tuser  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_DWIDTH_STATS_EN
  logic [31:0] r_stat_words;
  logic [31:0] r_stat_pkts;

  assign stat_word_count = r_stat_words;
  assign stat_pkt_count  = r_stat_pkts;

  // Free-running transfer counters; wrap naturally at 2^32.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_stat_words <= '0;
      r_stat_pkts  <= '0;
    end else if (w_xfer) begin
      r_stat_words <= r_stat_words + 32'd1;
      if (r_tlast) begin
        r_stat_pkts <= r_stat_pkts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_dwidth_converter.sv
// Self-checking bench for axis_dwidth_converter (default 64 -> 256, N=4).
`timescale 1ns/1ps

module tb_axis_dwidth_converter;

  localparam int SW = 64;
  localparam int MW = 256;
  localparam int UW = 128;
  localparam int N  = MW / SW;

  logic            aclk = 1'b0;
  logic            reset;
  logic [SW-1:0]   s_axis_tdata;
  logic [SW/8-1:0] s_axis_tkeep;
  logic [UW-1:0]   s_axis_tuser;
  logic            s_axis_tlast;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [MW-1:0]   m_axis_tdata;
  logic [MW/8-1:0] m_axis_tkeep;
  logic [UW-1:0]   m_axis_tuser;
  logic            m_axis_tlast;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
`ifdef AXIS_DWIDTH_STATS_EN
  logic [31:0]     stat_word_count;
  logic [31:0]     stat_pkt_count;
`endif

  axis_dwidth_converter #(
    .C_S_AXIS_DATA_WIDTH(SW),
    .C_M_AXIS_DATA_WIDTH(MW),
    .C_AXIS_TUSER_WIDTH (UW)
  ) dut (
    .aclk          (aclk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
`ifdef AXIS_DWIDTH_STATS_EN
    ,
    .stat_word_count(stat_word_count),
    .stat_pkt_count (stat_pkt_count)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [SW-1:0]   d;
    logic [SW/8-1:0] k;
    logic [UW-1:0]   u;
    logic            l;
  } beat_t;

  typedef struct packed {
    logic [MW-1:0]   d;
    logic [MW/8-1:0] k;
    logic [UW-1:0]   u;
    logic            l;
  } word_t;

  typedef struct packed {
    int                    n;
    logic [3:0][SW-1:0]    d;
    logic [3:0][SW/8-1:0]  k;
    logic [UW-1:0]         u;
    logic [MW-1:0]         ed;
    logic [MW/8-1:0]       ek;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic send_beat(input logic [SW-1:0] d, input logic [SW/8-1:0] k,
                           input logic [UW-1:0] u, input logic l);
    bit acc;
    int n;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk);
      #1;
      n++;
    end
    s_axis_tvalid = 1'b0;
    if (!acc) chk("send_timeout", 256'd0, 256'd1);
  endtask

  function automatic word_t cur_word();
    word_t w;
    w.d = m_axis_tdata;
    w.k = m_axis_tkeep;
    w.u = m_axis_tuser;
    w.l = m_axis_tlast;
    return w;
  endfunction

  vec_t  tv[5];
  word_t got[4];
  beat_t beats_q[$];
  word_t exp_q[$];

  initial begin
    // ---------------- vector table ----------------
    for (int i = 0; i < 5; i++) tv[i] = '0;
    tv[0].n = 4;
    tv[0].d[0] = 64'h1111111111111111; tv[0].d[1] = 64'h2222222222222222;
    tv[0].d[2] = 64'h3333333333333333; tv[0].d[3] = 64'h4444444444444444;
    tv[0].k = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tv[0].u = 128'h1234;
    tv[0].ed = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    tv[0].ek = 32'hFFFFFFFF;

    tv[1].n = 1;
    tv[1].d[0] = 64'hA5A5A5A5A5A5A5A5; tv[1].k[0] = 8'h0F; tv[1].u = 128'h40;
    tv[1].ed = {192'h0, 64'hA5A5A5A5A5A5A5A5};
    tv[1].ek = 32'h0000000F;

    tv[2].n = 2;
    tv[2].d[0] = 64'h0123456789ABCDEF; tv[2].d[1] = 64'hFEDCBA9876543210;
    tv[2].k[0] = 8'hFF; tv[2].k[1] = 8'h3C; tv[2].u = 128'h7;
    tv[2].ed = {128'h0, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
    tv[2].ek = 32'h00003CFF;

    tv[3].n = 3;
    tv[3].d[0] = 64'h1; tv[3].d[1] = 64'h2; tv[3].d[2] = 64'h3;
    tv[3].k[0] = 8'h01; tv[3].k[1] = 8'h80; tv[3].k[2] = 8'hF0;
    tv[3].u = 128'hBEEF_0000_0000_0000_0000_0000_0000_CAFE;
    tv[3].ed = {64'h0, 64'h3, 64'h2, 64'h1};
    tv[3].ek = 32'h00F08001;

    tv[4].n = 4;
    tv[4].d[0] = 64'h1; tv[4].d[1] = 64'h0;
    tv[4].d[2] = 64'hFFFFFFFFFFFFFFFF; tv[4].d[3] = 64'h8000000000000001;
    tv[4].k = {8'h81, 8'hFF, 8'h00, 8'h5A};
    tv[4].u = 128'h99;
    tv[4].ed = {64'h8000000000000001, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h1};
    tv[4].ek = 32'h81FF005A;

    // ---------------- reset state ----------------
    reset = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_ctrl", {m_axis_tvalid, m_axis_tlast, s_axis_tready}, 3'b000);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_side", {m_axis_tkeep, m_axis_tuser}, '0);
    reset = 1'b0;
    #1;
    chk("rel_tready", s_axis_tready, 1'b1);

    // ---------------- streaming 10-beat packet ----------------
    begin
      int nw;
      logic [7:0] b;
      nw = 0;
      m_axis_tready = 1'b1;
      @(posedge aclk);
      #1;
      for (int i = 0; i < 12; i++) begin
        if (i < 10) begin
          b = 8'(i + 1);
          s_axis_tdata  = {8{b}};
          s_axis_tkeep  = 8'hFF;
          s_axis_tuser  = 128'(i * 16 + 5);
          s_axis_tlast  = (i == 9);
          s_axis_tvalid = 1'b1;
        end else begin
          s_axis_tvalid = 1'b0;
          s_axis_tlast  = 1'b0;
        end
        @(negedge aclk);
        if (i < 10) chk($sformatf("stream_tready_%0d", i), s_axis_tready, 1'b1);
        if (m_axis_tvalid && m_axis_tready && nw < 4) begin
          got[nw] = cur_word();
          nw++;
        end
        @(posedge aclk);
        #1;
      end
      chk("stream_nwords", nw, 3);
      chk("stream_keep", {got[0].k, got[1].k, got[2].k}, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF});
      chk("stream_last", {got[0].l, got[1].l, got[2].l}, 3'b001);
      chk("stream_user0", got[0].u, 128'(0 * 16 + 5));
      chk("stream_user1", got[1].u, 128'(4 * 16 + 5));
      chk("stream_user2", got[2].u, 128'(8 * 16 + 5));
      chk("stream_data2", got[2].d, {128'h0, {8{8'h0A}}, {8{8'h09}}});
      chk("stream_data0", got[0].d, {{8{8'h04}}, {8{8'h03}}, {8{8'h02}}, {8{8'h01}}});
`ifdef AXIS_DWIDTH_STATS_EN
      chk("stat_words", stat_word_count, 32'd3);
      chk("stat_pkts", stat_pkt_count, 32'd1);
`endif
    end

    // ---------------- table-driven packets ----------------
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < tv[i].n; j++) begin
        send_beat(tv[i].d[j], tv[i].k[j],
                  (j == 0) ? tv[i].u : {$urandom, $urandom, $urandom, $urandom},
                  (j == tv[i].n - 1));
        if (j < tv[i].n - 1)
          chk($sformatf("vec%0d_early_valid_%0d", i, j), m_axis_tvalid, 1'b0);
      end
      chk($sformatf("vec%0d_data", i), m_axis_tdata, tv[i].ed);
      chk($sformatf("vec%0d_side", i), {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser},
          {1'b1, 1'b1, tv[i].ek, tv[i].u});
      @(posedge aclk);
      #1;
      chk($sformatf("vec%0d_drained", i), m_axis_tvalid, 1'b0);
    end

    // ---------------- backpressure ----------------
    m_axis_tready = 1'b0;
    send_beat(64'hA5A5A5A5A5A5A5A5, 8'h0F, 128'h40, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      chk($sformatf("bp_hold_%0d", c),
          {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser[7:0], m_axis_tdata[63:0]},
          {1'b0, 1'b1, 1'b1, 32'h0000000F, 8'h40, 64'hA5A5A5A5A5A5A5A5});
    end
    chk("bp_hold_upper", m_axis_tdata[255:64], 192'h0);
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b1;
    #1;
    chk("bp_release_tready", s_axis_tready, 1'b1);
    @(posedge aclk);
    #1;
    chk("bp_release_valid", m_axis_tvalid, 1'b0);

    // ---------------- reset mid-word ----------------
    send_beat(64'hDEADBEEFDEADBEEF, 8'hFF, 128'h5, 1'b0);
    send_beat(64'h0BADF00D0BADF00D, 8'h0F, 128'h6, 1'b0);
    chk("partial_word", {m_axis_tkeep, m_axis_tdata},
        {32'h00000FFF, 128'h0, 64'h0BADF00D0BADF00D, 64'hDEADBEEFDEADBEEF});
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_ctrl", {m_axis_tvalid, s_axis_tready}, 2'b00);
    chk("async_rst_data", {m_axis_tkeep, m_axis_tdata}, '0);
    @(posedge aclk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst2_tready", s_axis_tready, 1'b1);
    for (int j = 0; j < 4; j++) send_beat(tv[0].d[j], tv[0].k[j], (j == 0) ? 128'h77 : 128'h1, j == 3);
    chk("rst2_word", m_axis_tdata, tv[0].ed);
    chk("rst2_side", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser},
        {1'b1, 1'b1, 32'hFFFFFFFF, 128'h77});
    @(posedge aclk);
    #1;

    // ---------------- randomized packets vs packet-level model ----------------
    for (int p = 0; p < 40; p++) begin
      int len;
      beat_t pkt[$];
      word_t w;
      len = $urandom_range(1, 11);
      pkt.delete();
      for (int j = 0; j < len; j++) begin
        beat_t bb;
        bb.d = {$urandom, $urandom};
        bb.k = 8'($urandom);
        bb.u = {$urandom, $urandom, $urandom, $urandom};
        bb.l = (j == len - 1);
        pkt.push_back(bb);
        beats_q.push_back(bb);
      end
      for (int c = 0; c * N < len; c++) begin
        w = '0;
        for (int j = 0; j < N; j++) begin
          if (c * N + j < len) begin
            w.d[j*SW +: SW]     = pkt[c*N + j].d;
            w.k[j*SW/8 +: SW/8] = pkt[c*N + j].k;
          end
        end
        w.u = pkt[c*N].u;
        w.l = ((c + 1) * N >= len);
        exp_q.push_back(w);
      end
    end

    begin
      int bi;
      int cyc;
      bit acc;
      bit prev_stall;
      word_t prev;
      word_t cw;
      word_t e;
      bi = 0; cyc = 0; prev_stall = 1'b0; prev = '0;
      s_axis_tvalid = 1'b0;
      while ((bi < beats_q.size() || exp_q.size() > 0) && cyc < 20000) begin
        if (bi >= beats_q.size()) s_axis_tvalid = 1'b0;
        else if (!s_axis_tvalid) s_axis_tvalid = ($urandom_range(0, 3) != 0);
        if (bi < beats_q.size()) begin
          s_axis_tdata = beats_q[bi].d;
          s_axis_tkeep = beats_q[bi].k;
          s_axis_tuser = beats_q[bi].u;
          s_axis_tlast = beats_q[bi].l;
        end
        m_axis_tready = ($urandom_range(0, 3) != 0);
        @(negedge aclk);
        cw = cur_word();
        if (prev_stall) begin
          chk("rand_hold_data", cw.d, prev.d);
          chk("rand_hold_side", {m_axis_tvalid, cw.k, cw.u, cw.l}, {1'b1, prev.k, prev.u, prev.l});
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk("rand_extra_word", 256'd1, 256'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rand_data", cw.d, e.d);
            chk("rand_side", {cw.k, cw.u, cw.l}, {e.k, e.u, e.l});
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev = cw;
        acc = s_axis_tvalid && s_axis_tready;
        @(posedge aclk);
        #1;
        if (acc) begin
          bi++;
          s_axis_tvalid = 1'b0;
        end
        cyc++;
      end
      chk("rand_drained", {bi == beats_q.size(), exp_q.size() == 0}, 2'b11);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
